// File: rtl/muldiv_if.sv
// Request/response bundle between the CPU control path and the mul/div unit.
// The master side issues operations and reads back HI/LO and status.
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (output start, op, A, B, input busy, done, HI, LO);
   modport slave  (input start, op, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// One multiplier or quotient bit per cycle on magnitudes, sign fixed up in FIX.
module muldiv #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rstn,
   muldiv_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               is_div_q, neg_lo_q, neg_hi_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               busy_q, done_q;

   logic               accept;
   logic               sgn_op;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift, div_diff;
   logic [2*WIDTH-1:0] acc_step, acc_neg;
   logic [WIDTH-1:0]   quo_neg, rem_neg;

   assign accept = (state_q == IDLE) && bus.start && !bus.op[2];
   assign sgn_op = !bus.op[0];
   assign a_abs  = (sgn_op && bus.A[WIDTH-1]) ? -bus.A : bus.A;
   assign b_abs  = (sgn_op && bus.B[WIDTH-1]) ? -bus.B : bus.B;

   // Multiply: add into the upper half, shift the whole accumulator right.
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};

   // Divide: upper half is the partial remainder, lower half dividend/quotient.
   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, b_q};

   always_comb begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      if (is_div_q) begin
         if (!div_diff[WIDTH])
            acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         else
            acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   assign acc_neg = -acc_q;
   assign quo_neg = -acc_q[WIDTH-1:0];
   assign rem_neg = -acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = CALC;
         CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cnt_q    <= '0;
                  a_q      <= a_abs;
                  b_q      <= b_abs;
                  is_div_q <= bus.op[1];
                  // A zero divisor must leave the all-ones quotient unnegated.
                  neg_lo_q <= sgn_op && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1])
                              && !(bus.op[1] && (bus.B == '0));
                  neg_hi_q <= sgn_op && bus.A[WIDTH-1];
                  acc_q    <= bus.op[1] ? {{WIDTH{1'b0}}, a_abs} : '0;
                  busy_q   <= 1'b1;
               end else if (bus.start && bus.op == 3'd4) begin
                  hi_q <= bus.A;
               end else if (bus.start && bus.op == 3'd5) begin
                  lo_q <= bus.A;
               end
            end
            CALC: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CW'(1);
               if (!is_div_q) b_q <= b_q >> 1;
            end
            FIX: begin
               if (is_div_q) begin
                  lo_q <= neg_lo_q ? quo_neg : acc_q[WIDTH-1:0];
                  hi_q <= neg_hi_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
               end else begin
                  {hi_q, lo_q} <= neg_lo_q ? acc_neg : acc_q;
               end
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;
endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: expected HI/LO queued at issue, checked on done.
module tb_muldiv;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [63:0] exp_q[$];
   logic [31:0] model_hi = 32'h0;
   logic [31:0] model_lo = 32'h0;

   muldiv_if #(.WIDTH(32)) bus ();
   muldiv #(.WIDTH(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rstn && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got HI=%h LO=%h expected no done", bus.HI, bus.LO);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("result", {bus.HI, bus.LO}, e);
         end
      end
   end

   task automatic run_op(input string name, input logic [2:0] opc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input bit b2b, input bit inject);
      int busy_cnt;
      bit seen;
      $display("issue %s op=%0d A=%h B=%h", name, opc, a, b);
      bus.start = 1'b1; bus.op = opc; bus.A = a; bus.B = b;
      exp_q.push_back({ehi, elo});
      @(posedge clk);
      #1 bus.start = 1'b0; bus.op = 3'd6;
      busy_cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_cnt++;
         if (inject && i == 10) begin
            bus.start = 1'b1; bus.op = 3'd5; bus.A = 32'hDEADBEEF;
         end
         if (inject && i == 11) begin
            bus.start = 1'b0; bus.op = 3'd6;
         end
         if (i == 16) chk({name, "_hold"}, {bus.HI, bus.LO}, {model_hi, model_lo});
      end
      chk({name, "_done_seen"}, 64'(seen), 64'd1);
      chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
      chk({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      model_hi = ehi;
      model_lo = elo;
      if (!b2b) begin
         @(negedge clk);
         chk({name, "_done_single"}, 64'(bus.done), 64'd0);
      end
   endtask

   initial begin
      int dones;
      bus.start = 1'b0; bus.op = 3'd6; bus.A = '0; bus.B = '0;
      repeat (3) @(negedge clk);
      chk("reset_state", {30'h0, bus.busy, bus.done, bus.HI, bus.LO}, 64'h0);
      rstn = 1'b1;
      @(negedge clk);

      // MTHI then MTLO on consecutive cycles
      bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'h12345678;
      @(negedge clk);
      chk("mthi_hi", 64'(bus.HI), 64'h12345678);
      chk("mthi_status", {62'h0, bus.busy, bus.done}, 64'h0);
      bus.op = 3'd5; bus.A = 32'h9ABCDEF0;
      @(negedge clk);
      chk("mtlo_lo", 64'(bus.LO), 64'h9ABCDEF0);
      chk("mtlo_status", {62'h0, bus.busy, bus.done}, 64'h0);
      bus.start = 1'b0; bus.op = 3'd6;
      model_hi = 32'h12345678;
      model_lo = 32'h9ABCDEF0;
      @(negedge clk);

      run_op("mult_m3x5",   3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
      run_op("multu_max",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
      run_op("mult_m1xm1",  3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b1);
      run_op("div_m7_2",    3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
      run_op("divu_7_2",    3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b1, 1'b0);
      run_op("div_min_m1",  3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
      run_op("divu_7_0",    3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_op("div_m7_0",    3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, 1'b0);

      // Reserved opcode has no effect
      bus.start = 1'b1; bus.op = 3'd6; bus.A = 32'h0000FFFF; bus.B = 32'h1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("reserved_hilo", {bus.HI, bus.LO}, {model_hi, model_lo});
      chk("reserved_busy", 64'(bus.busy), 64'd0);

      // Reset in the middle of a MULTU
      $display("issue multu_3x4 then reset at cycle 10");
      bus.start = 1'b1; bus.op = 3'd1; bus.A = 32'd3; bus.B = 32'd4;
      @(posedge clk);
      #1 bus.start = 1'b0; bus.op = 3'd6;
      repeat (10) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("midreset_state", {30'h0, bus.busy, bus.done, bus.HI, bus.LO}, 64'h0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("midreset_no_done", 64'(dones), 64'd0);
      model_hi = 32'h0;
      model_lo = 32'h0;
      run_op("multu_3x4",   3'd1, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit with HI/LO result registers: the multi-cycle partner of the single-cycle combinational ALU. It handles MULT, MULTU, DIV, DIVU, MTHI and MTLO for the CPU datapath. It accepts one operation per start pulse, computes one bit per cycle, and exposes `busy` so the control unit can stall MFHI/MFLO and further mul/div instructions until the result lands in HI/LO.

## Interface
- `WIDTH`, default 32: operand width; all widths below are relative to this.
- `clk` input 1: clock; all state updates on the rising edge.
- `rstn` input 1: synchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `op` input 3: operation code.
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - 6 and 7 are reserved and ignored.
- `A` input WIDTH: rs operand; dividend or multiplicand.
- `B` input WIDTH: rt operand; divisor or multiplier.
- `busy` output 1: high while a MULT/DIV operation is in flight.
- `done` output 1: one-cycle pulse when HI/LO are updated by MULT/DIV.
- `HI` output WIDTH: high product half, or remainder.
- `LO` output WIDTH: low product half, or quotient.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE, `start`=1, op 0–3:**
  - Latch |A| and |B| for signed ops, raw A and B for unsigned ops.
  - Latch the result sign flags and the op.
  - Clear the 6-bit iteration counter and the partial accumulator.
  - Go to CALC.
- **IDLE, `start`=1, op 4 (MTHI):** HI <= A in the same edge. No state change, `busy` stays 0, no `done`.
- **IDLE, `start`=1, op 5 (MTLO):** LO <= A in the same edge. No state change, `busy` stays 0, no `done`.
- **IDLE, `start`=1, op 6/7:** no effect.
- **CALC, multiply:**
  - Shift-add, one multiplier bit per cycle, LSB first.
  - 2·WIDTH-bit unsigned accumulator.
- **CALC, divide:**
  - Restoring division, one quotient bit per cycle, MSB first.
  - WIDTH+1-bit partial-remainder subtractor.
- **CALC exit:** after WIDTH iterations (counter reaches WIDTH), go to FIX.
- **FIX:**
  - Apply sign correction and write HI/LO.
  - Assert `done` for the next cycle.
  - Return to IDLE.
- **Sign rules:**
  - MULT: product negated iff sign(A) xor sign(B).
  - DIV: quotient negated iff sign(A) xor sign(B); remainder takes the sign of A.
  - MULTU/DIVU: no correction.
- **Divide by zero (B=0, DIV or DIVU):** LO = all ones, HI = A (unmodified), normal latency. This must be special-cased for signed DIV.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO = 0x80000000, HI = 0. This is the natural result of the magnitude algorithm; no trap.
- **HI/LO hold:** old values are held throughout CALC and change only at the FIX edge, so MFHI/MFLO issued early (despite stall) see stale but stable data.
- **`start` in CALC or FIX:** ignored entirely, including MTHI/MTLO. The control unit must stall.
- **Reset during any state:** return to IDLE immediately; HI=LO=0, `busy`=0, `done`=0; the in-flight op is discarded.

## Timing
- **Reset values:** `busy`=0, `done`=0, HI=0, LO=0, state IDLE, counter 0.
- **Edge numbering (accept edge = edge 0):**
  - `busy` is 1 from after edge 0 through edge WIDTH+1.
  - Edges 1..WIDTH perform the iterations.
  - Edge WIDTH+1 (FIX) writes HI/LO and clears `busy`.
  - `done`=1 for exactly the cycle after edge WIDTH+1.
- **Total latency:** WIDTH+1 cycles (33 for WIDTH=32) from accept to HI/LO valid.
- **Back-to-back:** a new `start` is accepted in the same cycle `done` is high, since the unit is in IDLE by then.
- **Combinational outputs:** `busy` and `done` are registered. HI/LO are register outputs with no combinational path from A/B.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=5 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1. `busy` high 33 cycles; `done` single pulse.
- MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MULT on the same operands -> HI=0, LO=1.
- DIV A=0xFFFFFFF9 (−7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2 -> LO=3, HI=1.
  - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
  - DIV A=0xFFFFFFF9, B=0 -> LO=0xFFFFFFFF, HI=0xFFFFFFF9.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated one edge after each; `busy`/`done` never assert.
  - MTLO issued mid-MULT -> ignored; LO holds the old value until FIX.
- Start MULTU 3×4, assert `rstn`=0 at cycle 10 for one cycle -> next cycle HI=LO=0, `busy`=0, no `done`.
  - A fresh MULTU 3×4 afterwards yields LO=12, HI=0 in 33 cycles.
